// File: rtl/multicycle_fsm.sv
// multicycle_fsm: RV32I multicycle control FSM; define MULTICYCLE_FSM_ILLEGAL_TRAP_EN to trap unknown opcodes in ERROR.
module multicycle_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic [3:0] State,
  output logic       Illegal
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3, MEMWB = 4'd4, MEMWRITE = 4'd5,
    EXECUTER = 4'd6, EXECUTEI = 4'd7, ALUWB = 4'd8, BEQ = 4'd9, JAL = 4'd10, ERROR = 4'd11
  } state_t;
`ifdef MULTICYCLE_FSM_ILLEGAL_TRAP_EN
  localparam state_t BAD_OP = ERROR;
`else
  localparam state_t BAD_OP = FETCH;
`endif
  state_t state_q, state_d, cur;
  logic pc_update, branch, ir_w, mem_w, reg_w;
  always_ff @(posedge clk) state_q <= reset ? FETCH : state_d;
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:    state_d = MemReady ? DECODE : FETCH;
      DECODE:
        case (op)
          7'b0000011, 7'b0100011: state_d = MEMADR;
          7'b0110011:             state_d = EXECUTER;
          7'b0010011:             state_d = EXECUTEI;
          7'b1101111:             state_d = JAL;
          7'b1100011:             state_d = BEQ;
          default:                state_d = BAD_OP;
        endcase
      MEMADR:   state_d = op[5] ? MEMWRITE : MEMREAD;
      MEMREAD:  state_d = MemReady ? MEMWB : MEMREAD;
      MEMWRITE: state_d = MemReady ? FETCH : MEMWRITE;
      EXECUTER, EXECUTEI, JAL: state_d = ALUWB;
`ifdef MULTICYCLE_FSM_ILLEGAL_TRAP_EN
      ERROR:    state_d = ERROR;
`endif
      default:  state_d = FETCH;
    endcase
  end
  // Reset shows FETCH decode with every write enable masked off.
  always_comb begin
    cur = reset ? FETCH : state_q;
    pc_update = 1'b0;
    branch = 1'b0;
    ir_w = 1'b0;
    mem_w = 1'b0;
    reg_w = 1'b0;
    AdrSrc = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA = 2'b00;
    ALUSrcB = 2'b00;
    ALUOp = 2'b00;
    case (cur)
      FETCH: begin
        ir_w = MemReady;
        pc_update = MemReady;
        ALUSrcB = 2'b10;
        ResultSrc = 2'b10;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      MEMREAD: AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01;
        reg_w = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        mem_w = 1'b1;
      end
      EXECUTER: begin
        ALUSrcA = 2'b10;
        ALUOp = 2'b10;
      end
      EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp = 2'b10;
      end
      ALUWB: reg_w = 1'b1;
      BEQ: begin
        ALUSrcA = 2'b10;
        ALUOp = 2'b01;
        branch = 1'b1;
      end
      JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        pc_update = 1'b1;
      end
      default: ;
    endcase
  end
  always_comb begin
    ImmSrc = (op == 7'b0100011) ? 2'b01 :
             (op == 7'b1100011) ? 2'b10 :
             (op == 7'b1101111) ? 2'b11 : 2'b00;
  end
  assign PCWrite  = ~reset & (pc_update | (branch & Zero));
  assign IRWrite  = ~reset & ir_w;
  assign MemWrite = ~reset & mem_w;
  assign RegWrite = ~reset & reg_w;
  assign State    = cur;
`ifdef MULTICYCLE_FSM_ILLEGAL_TRAP_EN
  assign Illegal  = ~reset & (state_q == ERROR);
`else
  assign Illegal  = 1'b0;
`endif
endmodule
